// File: rtl/branch_predictor_btb.sv
// branch_predictor_btb: direct-mapped branch target buffer with a per-entry
// saturating-counter direction table. The decode stage looks up the fetch PC
// combinationally; execute reports resolved branches/jumps through the update
// port. A flush sweep FSM invalidates the whole table without a reset.
//
// Optional feature: define BP_GSHARE_EN to add a global history register that
// is XORed into the table index (gshare style) and the ghr_o/upd_ghr_i ports.

module branch_predictor_btb #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 64,
    parameter int CTR_W   = 2,
    parameter int GHR_W   = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  lookup_pc_i,
    output logic             predict_hit_o,
    output logic             predict_taken_o,
    output logic [XLEN-1:0]  predict_target_o,
    input  logic             upd_valid_i,
    input  logic [XLEN-1:0]  upd_pc_i,
    input  logic             upd_cond_i,
    input  logic             upd_taken_i,
    input  logic [XLEN-1:0]  upd_target_i,
    input  logic             flush_all_i,
`ifdef BP_GSHARE_EN
    output logic [GHR_W-1:0] ghr_o,
    input  logic [GHR_W-1:0] upd_ghr_i,
`endif
    output logic             busy_o
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;

    // Counter encodings: weakly-not-taken, weakly-taken and saturation ceiling
    localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(1) << (CTR_W - 1);
    localparam logic [CTR_W-1:0] CTR_WNT = CTR_WT - CTR_W'(1);
    localparam logic [CTR_W-1:0] CTR_MAX = {CTR_W{1'b1}};

    typedef enum logic {
        IDLE,
        SWEEP
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;

    logic               valid_q  [ENTRIES];
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [XLEN-1:0]    target_q [ENTRIES];
    logic [CTR_W-1:0]   ctr_q    [ENTRIES];

    logic [IDX_W-1:0]   lk_idx;
    logic [TAG_W-1:0]   lk_tag;
    logic [IDX_W-1:0]   up_idx;
    logic [TAG_W-1:0]   up_tag;

    logic               upd_accept;
    logic               upd_hit;
    logic [CTR_W-1:0]   upd_cur_ctr;
    logic               ent_we;
    logic               ctr_we;
    logic [CTR_W-1:0]   ctr_new;

    // Low PC bits never take part in indexing or tagging
    logic               unused_pc_bits;
    assign unused_pc_bits = ^{lookup_pc_i[1:0], upd_pc_i[1:0]};

    assign lk_tag = lookup_pc_i[XLEN-1:IDX_W+2];
    assign up_tag = upd_pc_i[XLEN-1:IDX_W+2];
    assign busy_o = (state_q == SWEEP);

    // Updates are accepted only while idle, and a flush request takes priority
    assign upd_accept = upd_valid_i && (state_q == IDLE) && !flush_all_i;

`ifdef BP_GSHARE_EN
    logic [GHR_W-1:0] ghr_q, ghr_d;
    logic [IDX_W-1:0] ghr_ext, upd_ghr_ext;

    // Zero-extend both history values to index width and fold them into the index
    always_comb begin
        ghr_ext                  = '0;
        upd_ghr_ext              = '0;
        ghr_ext[GHR_W-1:0]       = ghr_q;
        upd_ghr_ext[GHR_W-1:0]   = upd_ghr_i;
        lk_idx                   = lookup_pc_i[IDX_W+1:2] ^ ghr_ext;
        up_idx                   = upd_pc_i[IDX_W+1:2] ^ upd_ghr_ext;
    end

    // History shifts in each accepted conditional outcome; a sweep clears it
    always_comb begin
        ghr_d = ghr_q;
        if (state_q == SWEEP) begin
            ghr_d = '0;
        end else if (upd_accept && upd_cond_i) begin
            ghr_d = (ghr_q << 1) | GHR_W'(upd_taken_i);
        end
    end

    // Global history register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end

    assign ghr_o = ghr_q;
`else
    localparam int unused_ghr_w = GHR_W;

    // Plain PC indexing
    always_comb begin
        lk_idx = lookup_pc_i[IDX_W+1:2];
        up_idx = upd_pc_i[IDX_W+1:2];
    end
`endif

    // Zero-latency lookup; predictions are suppressed while the sweep runs
    always_comb begin
        predict_hit_o    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag) && (state_q == IDLE);
        predict_taken_o  = predict_hit_o && ctr_q[lk_idx][CTR_W-1];
        predict_target_o = predict_taken_o ? target_q[lk_idx] : (lookup_pc_i + XLEN'(4));
    end

    // Decide what an accepted update does to the entry at the update index
    always_comb begin
        upd_hit     = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
        upd_cur_ctr = ctr_q[up_idx];
        ent_we      = 1'b0;
        ctr_we      = 1'b0;
        ctr_new     = upd_cur_ctr;
        if (upd_accept) begin
            if (upd_taken_i) begin
                ent_we = 1'b1;
                ctr_we = 1'b1;
                if (!upd_cond_i) begin
                    ctr_new = CTR_MAX;
                end else if (upd_hit) begin
                    ctr_new = (upd_cur_ctr == CTR_MAX) ? upd_cur_ctr : upd_cur_ctr + CTR_W'(1);
                end else begin
                    ctr_new = CTR_WT;
                end
            end else if (upd_hit) begin
                ctr_we  = 1'b1;
                ctr_new = (upd_cur_ctr == '0) ? upd_cur_ctr : upd_cur_ctr - CTR_W'(1);
            end
        end
    end

    // Sweep FSM: walk every index once, then return to idle
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (flush_all_i) begin
                    state_d = SWEEP;
                    ptr_d   = '0;
                end
            end
            SWEEP: begin
                ptr_d = ptr_q + IDX_W'(1);
                if (ptr_q == IDX_W'(ENTRIES - 1)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state and sweep pointer registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Valid bits and counters: reset, cleared by the sweep, or written by updates
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= CTR_WNT;
            end
        end else if (state_q == SWEEP) begin
            valid_q[ptr_q] <= 1'b0;
            ctr_q[ptr_q]   <= CTR_WNT;
        end else begin
            if (ent_we) begin
                valid_q[up_idx] <= 1'b1;
            end
            if (ctr_we) begin
                ctr_q[up_idx] <= ctr_new;
            end
        end
    end

    // Tags and targets need no reset; they are qualified by the valid bits
    always_ff @(posedge clk) begin
        if (ent_we) begin
            tag_q[up_idx]    <= up_tag;
            target_q[up_idx] <= upd_target_i;
        end
    end

endmodule
